// File: rtl/pdp8i_pkg.sv
// rtl/pdp8i_pkg.sv - PDP-8/I major-state and opcode constants plus the major-state transfer function
package pdp8i_pkg;

  typedef enum logic [5:0] {
    MS_F  = 6'b000001,
    MS_D  = 6'b000010,
    MS_E  = 6'b000100,
    MS_WC = 6'b001000,
    MS_CA = 6'b010000,
    MS_B  = 6'b100000
  } mstate_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  // Processor-only successor; break arbitration is layered on top by the caller.
  function automatic mstate_t next_major(input mstate_t cur, input logic [2:0] op,
                                         input logic ind);
    mstate_t nxt;
    nxt = MS_F;
    case (cur)
      MS_F: begin
        if (op <= OP_JMS)      nxt = ind ? MS_D : MS_E;
        else if (op == OP_JMP) nxt = ind ? MS_D : MS_F;
        else                   nxt = MS_F;
      end
      MS_D:    nxt = (op == OP_JMP) ? MS_F : MS_E;
      MS_E:    nxt = MS_F;
      MS_WC:   nxt = MS_CA;
      MS_CA:   nxt = MS_B;
      MS_B:    nxt = MS_F;
      default: nxt = MS_F;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ts_gen.sv
// rtl/ts_gen.sv - time-state counter producing one-hot TS1-TS4 and 1-clk TP1-TP4
module ts_gen #(
  parameter int TS_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       halt_at_tp4,
  output logic [3:0] ts,
  output logic [3:0] tp,
  output logic       tp4
);

  localparam logic [3:0] LAST = 4'(TS_CYCLES - 1);

  logic       active;
  logic [1:0] phase;
  logic [3:0] cnt;
  logic       last;

  assign last = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      phase  <= 2'd0;
      cnt    <= 4'd0;
    end else if (!active) begin
      if (go) begin
        active <= 1'b1;
        phase  <= 2'd0;
        cnt    <= 4'd0;
      end
    end else if (last) begin
      cnt <= 4'd0;
      // TS4 wraps straight into TS1 unless the cycle ends in a halt
      if (phase == 2'd3 && halt_at_tp4) begin
        active <= 1'b0;
        phase  <= 2'd0;
      end else begin
        phase <= phase + 2'd1;
      end
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  always_comb begin
    ts  = active ? (4'b0001 << phase) : 4'b0000;
    tp  = (active && last) ? ts : 4'b0000;
    tp4 = tp[3];
  end

endmodule

// File: rtl/major_state_seq.sv
// rtl/major_state_seq.sv - PDP-8/I memory-cycle sequencer: run control, major state, data-break arbitration
module major_state_seq
  import pdp8i_pkg::*;
#(
  parameter int TS_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_cont,
  input  logic       key_stop,
  input  logic       sing_step,
  input  logic       sing_inst,
  input  logic [2:0] ir_op,
  input  logic       ind,
  input  logic       brk_rq,
  input  logic       brk_3cyc,
  output logic       run,
  output logic [3:0] ts,
  output logic [3:0] tp,
  output logic [5:0] mstate,
  output logic       brk_ack
);

  mstate_t ms_q, ms_d, nxt_ms, fin_ms;
  logic    run_d, ack_d, stop_q, stop_d;
  logic    go, decide, grant, halt;

  assign go     = !run && (key_start || key_cont);
  assign mstate = ms_q;

  ts_gen #(.TS_CYCLES(TS_CYCLES)) u_ts_gen (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .halt_at_tp4 (halt),
    .ts          (ts),
    .tp          (tp),
    .tp4         (decide)
  );

  always_comb begin
    nxt_ms = next_major(ms_q, ir_op, ind);
    // A break may only replace a fetch, never split an instruction's F/D/E chain
    grant  = (nxt_ms == MS_F) && brk_rq;
    fin_ms = grant ? (brk_3cyc ? MS_WC : MS_B) : nxt_ms;
    halt   = key_stop || stop_q || sing_step || (sing_inst && !grant && nxt_ms == MS_F);

    ms_d   = ms_q;
    run_d  = run;
    ack_d  = 1'b0;
    // A stop pressed mid-cycle is held until the next TP4 decision
    stop_d = run && (stop_q || key_stop);

    if (go) begin
      run_d = 1'b1;
      if (key_start) ms_d = MS_F;
    end
    if (decide) begin
      ms_d   = fin_ms;
      ack_d  = grant;
      stop_d = 1'b0;
      if (halt) run_d = 1'b0;
    end
  end

  // brk_ack is registered at the TP4 edge, so it is seen in the first clk of the break cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_q    <= MS_F;
      run     <= 1'b0;
      brk_ack <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      ms_q    <= ms_d;
      run     <= run_d;
      brk_ack <= ack_d;
      stop_q  <= stop_d;
    end
  end

endmodule

// File: tb/tb_major_state_seq.sv
// tb/tb_major_state_seq.sv - self-checking bench for major_state_seq
module tb_major_state_seq;
  import pdp8i_pkg::*;

  logic       clk = 1'b0;
  logic       rst, key_start, key_cont, key_stop, sing_step, sing_inst;
  logic [2:0] ir_op;
  logic       ind, brk_rq, brk_3cyc;
  logic       run, brk_ack;
  logic [3:0] ts, tp;
  logic [5:0] mstate;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         key;   // 0 none, 1 start, 2 cont
    logic [2:0] op;
    logic       ind, brk, b3, sstep, sinst, stop;
    logic [5:0] ms;
    logic       ack, run;
  } vec_t;

  typedef struct {
    logic [5:0] ms;
    logic       ack, run;
  } exp_t;

  vec_t vt[27];
  exp_t sb[$];

  major_state_seq #(.TS_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_cont(key_cont),
    .key_stop(key_stop), .sing_step(sing_step), .sing_inst(sing_inst),
    .ir_op(ir_op), .ind(ind), .brk_rq(brk_rq), .brk_3cyc(brk_3cyc),
    .run(run), .ts(ts), .tp(tp), .mstate(mstate), .brk_ack(brk_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tp4(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tp == 4'b1000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic vec_t mk(int key, int op, bit i, bit brk, bit b3, bit sstep, bit sinst,
                              bit stop, logic [5:0] ms, bit ack, bit r);
    vec_t v;
    v.key = key; v.op = 3'(op); v.ind = i; v.brk = brk; v.b3 = b3;
    v.sstep = sstep; v.sinst = sinst; v.stop = stop; v.ms = ms; v.ack = ack; v.run = r;
    return v;
  endfunction

  initial begin
    bit         ok;
    exp_t       e;
    logic [5:0] prev_ms;
    logic [3:0] e_ts;

    //        key op ind brk b3 sst sin stp  ms     ack run
    vt[0]  = mk(0, 7, 0, 0, 0, 0, 0, 0, MS_F,  0, 1);
    vt[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0, MS_D,  0, 1);
    vt[2]  = mk(0, 1, 1, 0, 0, 0, 0, 0, MS_E,  0, 1);
    vt[3]  = mk(0, 7, 0, 0, 0, 0, 0, 0, MS_F,  0, 1);
    vt[4]  = mk(0, 5, 1, 0, 0, 0, 0, 0, MS_D,  0, 1);
    vt[5]  = mk(0, 5, 1, 0, 0, 0, 0, 0, MS_F,  0, 1);
    vt[6]  = mk(0, 5, 0, 0, 0, 0, 0, 0, MS_F,  0, 1);
    vt[7]  = mk(0, 2, 0, 1, 1, 0, 0, 0, MS_E,  0, 1);
    vt[8]  = mk(0, 2, 0, 1, 1, 0, 0, 0, MS_WC, 1, 1);
    vt[9]  = mk(0, 2, 0, 1, 1, 0, 0, 0, MS_CA, 0, 1);
    vt[10] = mk(0, 2, 0, 1, 1, 0, 0, 0, MS_B,  0, 1);
    vt[11] = mk(0, 2, 0, 1, 0, 0, 0, 0, MS_B,  1, 1);
    vt[12] = mk(0, 2, 0, 0, 0, 0, 0, 0, MS_F,  0, 1);
    vt[13] = mk(0, 3, 0, 0, 0, 0, 0, 0, MS_E,  0, 1);
    vt[14] = mk(0, 4, 1, 0, 0, 0, 0, 0, MS_F,  0, 1);
    vt[15] = mk(0, 6, 1, 0, 0, 0, 0, 0, MS_F,  0, 1);
    vt[16] = mk(0, 1, 1, 0, 0, 0, 1, 0, MS_D,  0, 1);
    vt[17] = mk(0, 1, 1, 0, 0, 0, 1, 0, MS_E,  0, 1);
    vt[18] = mk(0, 1, 1, 0, 0, 0, 1, 0, MS_F,  0, 0);
    vt[19] = mk(2, 7, 0, 0, 0, 0, 0, 0, MS_F,  0, 1);
    vt[20] = mk(0, 1, 0, 0, 0, 1, 0, 0, MS_E,  0, 0);
    vt[21] = mk(2, 1, 0, 0, 0, 1, 0, 0, MS_F,  0, 0);
    vt[22] = mk(2, 7, 0, 0, 0, 0, 0, 1, MS_F,  0, 0);
    vt[23] = mk(1, 7, 0, 1, 1, 0, 1, 0, MS_WC, 1, 1);
    vt[24] = mk(0, 7, 0, 0, 0, 0, 1, 0, MS_CA, 0, 1);
    vt[25] = mk(0, 7, 0, 0, 0, 0, 1, 0, MS_B,  0, 1);
    vt[26] = mk(0, 7, 0, 0, 0, 0, 1, 0, MS_F,  0, 0);

    rst = 1'b1; key_start = 1'b0; key_cont = 1'b0; key_stop = 1'b0;
    sing_step = 1'b0; sing_inst = 1'b0; ir_op = 3'd7; ind = 1'b0;
    brk_rq = 1'b0; brk_3cyc = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_run", run, 0);
    chk("rst_ts", ts, 0);
    chk("rst_tp", tp, 0);
    chk("rst_mstate", mstate, 6'b000001);
    chk("rst_ack", brk_ack, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ts", ts, 0);

    // First cycle: every clk of every time state and pulse
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      e_ts = 4'(1 << (k / 5));
      chk($sformatf("ts_clk%0d", k), ts, e_ts);
      chk($sformatf("tp_clk%0d", k), tp, (k % 5 == 4) ? e_ts : 4'b0000);
      chk($sformatf("ms_clk%0d", k), mstate, MS_F);
    end
    @(negedge clk);
    chk("wrap_ts1", ts, 4'b0001);
    chk("wrap_run", run, 1);
    prev_ms = MS_F;

    for (int n = 0; n < 27; n++) begin
      if (vt[n].key != 0) begin
        if (vt[n].key == 1) key_start = 1'b1; else key_cont = 1'b1;
        @(negedge clk);
        key_start = 1'b0; key_cont = 1'b0;
        chk($sformatf("v%0d_key_run", n), run, 1);
        chk($sformatf("v%0d_key_ts", n), ts, 4'b0001);
        chk($sformatf("v%0d_key_ms", n), mstate, (vt[n].key == 1) ? MS_F : prev_ms);
      end
      ir_op = vt[n].op; ind = vt[n].ind; brk_rq = vt[n].brk; brk_3cyc = vt[n].b3;
      sing_step = vt[n].sstep; sing_inst = vt[n].sinst;
      if (vt[n].stop) begin
        key_stop = 1'b1;
        @(negedge clk);
        key_stop = 1'b0;
      end
      wait_tp4(ok);
      chk($sformatf("v%0d_tp4_seen", n), ok, 1);
      sb.push_back('{ms: vt[n].ms, ack: vt[n].ack, run: vt[n].run});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_ms", n), mstate, e.ms);
      chk($sformatf("v%0d_ack", n), brk_ack, e.ack);
      chk($sformatf("v%0d_run", n), run, e.run);
      chk($sformatf("v%0d_ts", n), ts, e.run ? 4'b0001 : 4'b0000);
      prev_ms = e.ms;
      @(negedge clk);
      chk($sformatf("v%0d_ack_drop", n), brk_ack, 0);
    end

    // Halt in D, then start and cont together must restart at F
    brk_rq = 1'b0; sing_inst = 1'b0; sing_step = 1'b1; ir_op = 3'd1; ind = 1'b1;
    key_cont = 1'b1;
    @(negedge clk);
    key_cont = 1'b0;
    wait_tp4(ok);
    chk("h_tp4_seen", ok, 1);
    @(negedge clk);
    chk("h_halt_ms", mstate, MS_D);
    chk("h_halt_run", run, 0);
    sing_step = 1'b0;
    key_start = 1'b1; key_cont = 1'b1;
    @(negedge clk);
    key_start = 1'b0; key_cont = 1'b0;
    chk("both_keys_ms", mstate, MS_F);
    chk("both_keys_run", run, 1);
    wait_tp4(ok);
    chk("h2_tp4_seen", ok, 1);
    @(negedge clk);
    chk("h2_ms", mstate, MS_D);

    // Keys are ignored while running
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    chk("ign_key_ms", mstate, MS_D);
    chk("ign_key_ts", ts, 4'b0001);

    // Asynchronous reset in TS3
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ts == 4'b0100) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ts3_seen", ok, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_ts", ts, 0);
    chk("arst_tp", tp, 0);
    chk("arst_run", run, 0);
    chk("arst_ms", mstate, MS_F);
    chk("arst_ack", brk_ack, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_run", run, 0);
    chk("post_rst_ts", ts, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
